// File: rtl/bus_sequencer.sv
// Initiator side of the master bus: queues source->destination transfer requests
// and drives the interconnect IDs/commands one transfer at a time.
module bus_sequencer #(
  parameter int WORD_W  = 16,
  parameter int ID_W    = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15,
  parameter logic [ID_W-1:0] ID_IDLE = {ID_W{1'b0}}
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ID_W-1:0]   i_req_src_id,
  input  logic [ID_W-1:0]   i_req_src_cmd,
  input  logic [ID_W-1:0]   i_req_dst_id,
  input  logic [ID_W-1:0]   i_req_dst_cmd,
  output logic [ID_W-1:0]   o_write_id,
  output logic [ID_W-1:0]   o_write_command,
  output logic [ID_W-1:0]   o_read_id,
  output logic [ID_W-1:0]   o_read_command,
  input  logic              i_bus_valid,
  input  logic [WORD_W-1:0] i_bus_data,
  output logic              o_done_valid,
  output logic              o_done_err,
  output logic [WORD_W-1:0] o_done_data,
  output logic              o_busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = 8;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_REJECT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  logic [4*ID_W-1:0] fifo_mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r, count_next_s;
  logic              req_ready_r;
  state_t            state_r, state_next_s;
  logic [TO_W-1:0]   to_cnt_r, to_cnt_next_s;

  logic [ID_W-1:0]   write_id_r, write_cmd_r, read_id_r, read_cmd_r;
  logic [ID_W-1:0]   write_id_next_s, write_cmd_next_s, read_id_next_s, read_cmd_next_s;
  logic              done_valid_r, done_err_r, busy_r;
  logic              done_valid_next_s, done_err_next_s, busy_next_s;
  logic [WORD_W-1:0] done_data_r, done_data_next_s;

  logic              push_s, pop_s;
  logic [4*ID_W-1:0] head_s;
  logic [ID_W-1:0]   head_src_id_s, head_src_cmd_s, head_dst_id_s, head_dst_cmd_s;

  assign push_s         = i_req_valid & req_ready_r;
  assign pop_s          = (state_r == S_IDLE) && (count_r != {CNT_W{1'b0}});
  assign head_s         = fifo_mem_r[rd_ptr_r];
  assign head_src_id_s  = head_s[4*ID_W-1 -: ID_W];
  assign head_src_cmd_s = head_s[3*ID_W-1 -: ID_W];
  assign head_dst_id_s  = head_s[2*ID_W-1 -: ID_W];
  assign head_dst_cmd_s = head_s[ID_W-1:0];

  // FIFO occupancy for the coming cycle; ready is registered from it
  always_comb begin
    count_next_s = count_r;
    if (push_s && !pop_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (!push_s && pop_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Next-state and next-output logic; outputs follow the state being entered
  always_comb begin
    state_next_s      = state_r;
    to_cnt_next_s     = to_cnt_r;
    write_id_next_s   = write_id_r;
    write_cmd_next_s  = write_cmd_r;
    read_id_next_s    = read_id_r;
    read_cmd_next_s   = read_cmd_r;
    done_valid_next_s = 1'b0;
    done_err_next_s   = 1'b0;
    done_data_next_s  = {WORD_W{1'b0}};
    case (state_r)
      S_IDLE: begin
        if (pop_s) begin
          if ((head_src_id_s == ID_IDLE) || (head_dst_id_s == ID_IDLE)) begin
            state_next_s = S_REJECT;
          end else begin
            state_next_s     = S_ISSUE;
            to_cnt_next_s    = {TO_W{1'b0}};
            write_id_next_s  = head_src_id_s;
            write_cmd_next_s = head_src_cmd_s;
            read_id_next_s   = head_dst_id_s;
            read_cmd_next_s  = head_dst_cmd_s;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        to_cnt_next_s = to_cnt_r + TO_ONE;
        // Bus valid wins over a timeout landing in the same cycle
        if (i_bus_valid || (to_cnt_r == TO_LAST)) begin
          state_next_s      = S_DONE;
          done_valid_next_s = 1'b1;
          done_err_next_s   = ~i_bus_valid;
          done_data_next_s  = i_bus_valid ? i_bus_data : {WORD_W{1'b0}};
          write_id_next_s   = ID_IDLE;
          write_cmd_next_s  = {ID_W{1'b0}};
          read_id_next_s    = ID_IDLE;
          read_cmd_next_s   = {ID_W{1'b0}};
        end else begin
          state_next_s = S_ISSUE;
        end
      end
      S_REJECT: begin
        state_next_s      = S_DONE;
        done_valid_next_s = 1'b1;
        done_err_next_s   = 1'b1;
      end
      S_DONE: begin
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s     = S_IDLE;
        write_id_next_s  = ID_IDLE;
        write_cmd_next_s = {ID_W{1'b0}};
        read_id_next_s   = ID_IDLE;
        read_cmd_next_s  = {ID_W{1'b0}};
      end
    endcase
    busy_next_s = (count_next_s != {CNT_W{1'b0}}) || (state_next_s != S_IDLE);
  end

  // Request storage; contents are don't-care until pushed
  always_ff @(posedge i_Clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {i_req_src_id, i_req_src_cmd, i_req_dst_id, i_req_dst_cmd};
    end
  end

  // State, FIFO bookkeeping and registered outputs
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state_r      <= S_IDLE;
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      req_ready_r  <= 1'b1;
      to_cnt_r     <= {TO_W{1'b0}};
      write_id_r   <= ID_IDLE;
      write_cmd_r  <= {ID_W{1'b0}};
      read_id_r    <= ID_IDLE;
      read_cmd_r   <= {ID_W{1'b0}};
      done_valid_r <= 1'b0;
      done_err_r   <= 1'b0;
      done_data_r  <= {WORD_W{1'b0}};
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      wr_ptr_r     <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r     <= pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      count_r      <= count_next_s;
      req_ready_r  <= (count_next_s != CNT_FULL);
      to_cnt_r     <= to_cnt_next_s;
      write_id_r   <= write_id_next_s;
      write_cmd_r  <= write_cmd_next_s;
      read_id_r    <= read_id_next_s;
      read_cmd_r   <= read_cmd_next_s;
      done_valid_r <= done_valid_next_s;
      done_err_r   <= done_err_next_s;
      done_data_r  <= done_data_next_s;
      busy_r       <= busy_next_s;
    end
  end

  assign o_req_ready     = req_ready_r;
  assign o_write_id      = write_id_r;
  assign o_write_command = write_cmd_r;
  assign o_read_id       = read_id_r;
  assign o_read_command  = read_cmd_r;
  assign o_done_valid    = done_valid_r;
  assign o_done_err      = done_err_r;
  assign o_done_data     = done_data_r;
  assign o_busy          = busy_r;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer with a scoreboard of expected completions.
module tb_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  src_id, src_cmd, dst_id, dst_cmd;
  logic [3:0]  write_id, write_command, read_id, read_command;
  logic        bus_valid;
  logic [15:0] bus_data;
  logic        done_valid, done_err;
  logic [15:0] done_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]  wid, wcmd, rid, rcmd;
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic [3:0] seen_wid, seen_wcmd, seen_rid, seen_rcmd;

  always #5 clk = ~clk;

  bus_sequencer dut (
    .i_Clk          (clk),
    .i_Reset        (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_src_id   (src_id),
    .i_req_src_cmd  (src_cmd),
    .i_req_dst_id   (dst_id),
    .i_req_dst_cmd  (dst_cmd),
    .o_write_id     (write_id),
    .o_write_command(write_command),
    .o_read_id      (read_id),
    .o_read_command (read_command),
    .i_bus_valid    (bus_valid),
    .i_bus_data     (bus_data),
    .o_done_valid   (done_valid),
    .o_done_err     (done_err),
    .o_done_data    (done_data),
    .o_busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one request, hold it until accepted, record expected completion
  task automatic push_req(input logic [3:0] s, input logic [3:0] sc, input logic [3:0] d,
                          input logic [3:0] dc, input logic e, input logic [15:0] dat,
                          output int waited);
    logic acc;
    exp_t x;
    acc = 1'b0;
    waited = 0;
    req_valid = 1'b1;
    src_id = s; src_cmd = sc; dst_id = d; dst_cmd = dc;
    for (int i = 0; i < 200; i++) begin
      acc = req_ready;
      tick();
      if (acc) break;
      waited++;
    end
    req_valid = 1'b0;
    check("push_accepted", {31'd0, acc}, 32'd1);
    if ((s == 4'd0) || (d == 4'd0)) begin
      x.wid = 4'd0; x.wcmd = 4'd0; x.rid = 4'd0; x.rcmd = 4'd0;
    end else begin
      x.wid = s; x.wcmd = sc; x.rid = d; x.rcmd = dc;
    end
    x.err = e;
    x.data = dat;
    if (acc) exp_q.push_back(x);
  endtask

  task automatic wait_ports(output int n);
    n = 0;
    while ((write_id == 4'd0) && (n < 10)) begin
      tick();
      n++;
    end
    check("ports_driven", {28'd0, write_id == 4'd0 ? 4'd0 : 4'd1}, 32'd1);
  endtask

  // Completion monitor: compares every done pulse against the scoreboard head
  always @(negedge clk) begin
    if (!rst_n) begin
      seen_wid <= 4'd0; seen_wcmd <= 4'd0; seen_rid <= 4'd0; seen_rcmd <= 4'd0;
    end else begin
      if (write_id != 4'd0) begin seen_wid <= write_id; seen_wcmd <= write_command; end
      if (read_id != 4'd0)  begin seen_rid <= read_id;  seen_rcmd <= read_command;  end
      if (done_valid) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_done: observed=1 expected=0");
        end
        if (exp_q.size() != 0) begin
          exp_t x;
          x = exp_q.pop_front();
          check("sb_err",  {31'd0, done_err}, {31'd0, x.err});
          check("sb_data", {16'd0, done_data}, {16'd0, x.data});
          check("sb_wid",  {28'd0, seen_wid},  {28'd0, x.wid});
          check("sb_wcmd", {28'd0, seen_wcmd}, {28'd0, x.wcmd});
          check("sb_rid",  {28'd0, seen_rid},  {28'd0, x.rid});
          check("sb_rcmd", {28'd0, seen_rcmd}, {28'd0, x.rcmd});
        end
        seen_wid <= 4'd0; seen_wcmd <= 4'd0; seen_rid <= 4'd0; seen_rcmd <= 4'd0;
      end
    end
  end

  initial begin
    int w;
    int n;
    rst_n = 1'b0; req_valid = 1'b0; bus_valid = 1'b0; bus_data = 16'h0;
    src_id = 4'd0; src_cmd = 4'd0; dst_id = 4'd0; dst_cmd = 4'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_write_id", {28'd0, write_id}, 32'd0);
    check("rst_write_cmd", {28'd0, write_command}, 32'd0);
    check("rst_read_id", {28'd0, read_id}, 32'd0);
    check("rst_read_cmd", {28'd0, read_command}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done_valid}, 32'd0);

    // bus valid while idle must be ignored
    bus_valid = 1'b1; bus_data = 16'hFFFF;
    repeat (3) begin
      tick();
      check("idle_valid_no_done", {31'd0, done_valid}, 32'd0);
    end
    bus_valid = 1'b0;

    // single transfer, valid on second ISSUE cycle
    push_req(4'd1, 4'd3, 4'd2, 4'd5, 1'b0, 16'h1234, w);
    check("single_pre_ports", {28'd0, write_id}, 32'd0);
    tick();
    check("single_c1_ports", {16'd0, write_id, write_command, read_id, read_command}, 32'h1325);
    check("single_c1_busy", {31'd0, busy}, 32'd1);
    tick();
    check("single_c2_ports", {16'd0, write_id, write_command, read_id, read_command}, 32'h1325);
    bus_valid = 1'b1; bus_data = 16'h1234;
    tick();
    bus_valid = 1'b0; bus_data = 16'h0;
    check("single_done", {31'd0, done_valid}, 32'd1);
    check("single_err", {31'd0, done_err}, 32'd0);
    check("single_data", {16'd0, done_data}, 32'h1234);
    check("single_ids_idle", {16'd0, write_id, write_command, read_id, read_command}, 32'h0);
    tick();
    check("single_done_end", {31'd0, done_valid}, 32'd0);
    check("single_busy_end", {31'd0, busy}, 32'd0);

    // src == dst, valid on the very first ISSUE cycle
    push_req(4'd5, 4'd6, 4'd5, 4'd7, 1'b0, 16'h0A5A, w);
    tick();
    check("same_id_ports", {16'd0, write_id, write_command, read_id, read_command}, 32'h5657);
    bus_valid = 1'b1; bus_data = 16'h0A5A;
    tick();
    bus_valid = 1'b0; bus_data = 16'h0;
    check("same_id_done", {31'd0, done_valid}, 32'd1);
    tick();

    // timeout: ports held for TIMEOUT cycles
    push_req(4'd1, 4'd7, 4'd2, 4'd4, 1'b1, 16'h0000, w);
    wait_ports(n);
    n = 0;
    while ((write_id != 4'd0) && (n < 100)) begin
      n++;
      tick();
    end
    check("timeout_cycles", n, 32'd15);
    check("timeout_done", {31'd0, done_valid}, 32'd1);
    check("timeout_err", {31'd0, done_err}, 32'd1);
    check("timeout_data", {16'd0, done_data}, 32'd0);
    tick();

    // valid arrives on the last possible ISSUE cycle
    push_req(4'd3, 4'd1, 4'd4, 4'd2, 1'b0, 16'hBEEF, w);
    wait_ports(n);
    repeat (14) tick();
    check("late_valid_ports", {28'd0, write_id}, 32'd3);
    bus_valid = 1'b1; bus_data = 16'hBEEF;
    tick();
    bus_valid = 1'b0; bus_data = 16'h0;
    check("late_valid_done", {31'd0, done_valid}, 32'd1);
    check("late_valid_err", {31'd0, done_err}, 32'd0);
    tick();

    // reject on idle source, then on idle destination
    push_req(4'd0, 4'd1, 4'd2, 4'd3, 1'b1, 16'h0000, w);
    tick();
    check("reject_ports", {16'd0, write_id, write_command, read_id, read_command}, 32'h0);
    check("reject_no_done", {31'd0, done_valid}, 32'd0);
    tick();
    check("reject_done", {31'd0, done_valid}, 32'd1);
    check("reject_err", {31'd0, done_err}, 32'd1);
    tick();
    push_req(4'd3, 4'd1, 4'd0, 4'd3, 1'b1, 16'h0000, w);
    repeat (3) tick();

    // backpressure: bus never answers, six requests offered back to back
    push_req(4'd1, 4'd1, 4'd2, 4'd2, 1'b1, 16'h0, w);
    push_req(4'd3, 4'd3, 4'd4, 4'd4, 1'b1, 16'h0, w);
    push_req(4'd5, 4'd5, 4'd6, 4'd6, 1'b1, 16'h0, w);
    push_req(4'd7, 4'd7, 4'd8, 4'd8, 1'b1, 16'h0, w);
    push_req(4'd9, 4'd9, 4'd10, 4'd10, 1'b1, 16'h0, w);
    check("full_ready_low", {31'd0, req_ready}, 32'd0);
    push_req(4'd11, 4'd1, 4'd12, 4'd2, 1'b1, 16'h0, w);
    check("full_sixth_held", {31'd0, w > 10}, 32'd1);
    n = 0;
    while ((busy || exp_q.size() != 0) && (n < 400)) begin
      tick();
      n++;
    end
    check("full_drained", exp_q.size(), 32'd0);
    check("full_busy_low", {31'd0, busy}, 32'd0);

    // reset during ISSUE with three requests queued
    push_req(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 16'h0, w);
    push_req(4'd2, 4'd2, 4'd3, 4'd3, 1'b1, 16'h0, w);
    push_req(4'd4, 4'd4, 4'd5, 4'd5, 1'b1, 16'h0, w);
    push_req(4'd6, 4'd6, 4'd7, 4'd7, 1'b1, 16'h0, w);
    repeat (2) tick();
    check("mid_rst_issue", {28'd0, write_id}, 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_async_ports", {16'd0, write_id, write_command, read_id, read_command}, 32'h0);
    check("mid_rst_done", {31'd0, done_valid}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (20) tick();
    check("mid_rst_still_idle", {16'd0, write_id, write_command, read_id, read_command}, 32'h0);
    check("mid_rst_busy_end", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
